// File: rtl/conv4.sv
// conv4: 4x4 signed convolution of a sliding 4-column image window, one output row per instance.
// data_out registers on the edge that accepts the 4th (or later) image column; no backpressure, valid_in qualifies every beat.
module conv4 #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 4,
  parameter int STRIDE      = 1,
  parameter int PADDING     = 1,
  parameter int CONV_OUTPUT = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] data_in0,
  input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] data_in1,
  input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] data_in2,
  input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] data_in3,
  input  logic                              kernel_load,
  input  logic                              valid_in,
  input  logic                              valid_out,
  output logic [CONV_OUTPUT-1:0]            data_out
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = PROD_W + 4;
  localparam int PH_W   = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic signed [DATA_WIDTH-1:0] lane    [4];
  logic signed [DATA_WIDTH-1:0] w       [4][4];
  logic signed [DATA_WIDTH-1:0] x       [4][4];
  logic signed [DATA_WIDTH-1:0] win_nxt [4][4];
  logic signed [PROD_W-1:0]     prod    [4][4];
  logic signed [ACC_W-1:0]      acc;

  logic [1:0]      kc;
  logic [2:0]      fill;
  logic [2:0]      fill_nxt;
  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] phase_nxt;
  logic            img_beat;
  logic            win_full;
  logic            emit;
  logic            unused_bits;

  // Only the low DATA_WIDTH bits of each lane carry data.
  assign lane[0] = data_in0[DATA_WIDTH-1:0];
  assign lane[1] = data_in1[DATA_WIDTH-1:0];
  assign lane[2] = data_in2[DATA_WIDTH-1:0];
  assign lane[3] = data_in3[DATA_WIDTH-1:0];

  assign unused_bits = ^{data_in0[DATA_WIDTH*KERNEL_SIZE-1:DATA_WIDTH],
                         data_in1[DATA_WIDTH*KERNEL_SIZE-1:DATA_WIDTH],
                         data_in2[DATA_WIDTH*KERNEL_SIZE-1:DATA_WIDTH],
                         data_in3[DATA_WIDTH*KERNEL_SIZE-1:DATA_WIDTH],
                         1'(PADDING)};

  // Window as it will look after this beat's shift; the MAC reads it so the result lands on the same edge.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      win_nxt[r][0] = x[r][1];
      win_nxt[r][1] = x[r][2];
      win_nxt[r][2] = x[r][3];
      win_nxt[r][3] = lane[r];
    end
  end

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        prod[r][c] = w[r][c] * win_nxt[r][c];
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        acc = acc + {{(ACC_W-PROD_W){prod[r][c][PROD_W-1]}}, prod[r][c]};
      end
    end
  end

  assign img_beat  = valid_in && !kernel_load;
  assign fill_nxt  = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
  assign win_full  = (fill_nxt == 3'd4);
  assign phase_nxt = (int'(phase) == STRIDE - 1) ? '0 : phase + PH_W'(1);
  assign emit      = img_beat && win_full && (phase == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          w[r][c] <= '0;
          x[r][c] <= '0;
        end
      end
      kc       <= '0;
      fill     <= '0;
      phase    <= '0;
      data_out <= '0;
    end else if (valid_in) begin
      if (kernel_load) begin
        for (int r = 0; r < 4; r++) begin
          w[r][kc] <= lane[r];
        end
        kc    <= kc + 2'd1;
        fill  <= '0;
        phase <= '0;
      end else begin
        kc <= '0;
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            x[r][c] <= win_nxt[r][c];
          end
        end
        fill <= fill_nxt;
        // Stride phase counts full-window beats even when the output is gated off.
        if (win_full) begin
          phase <= phase_nxt;
        end
        if (emit && valid_out) begin
          data_out <= acc[CONV_OUTPUT-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv4.sv
// Scoreboard bench for conv4: one STRIDE=1 and one STRIDE=2 instance share stimulus.
`timescale 1ns/1ps
module tb_conv4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] data_in0 = '0;
  logic [63:0] data_in1 = '0;
  logic [63:0] data_in2 = '0;
  logic [63:0] data_in3 = '0;
  logic        kernel_load = 1'b0;
  logic        valid_in = 1'b0;
  logic        valid_out = 1'b0;
  logic [31:0] data_out_s1;
  logic [31:0] data_out_s2;

  always #5 clk = ~clk;

  conv4 #(.STRIDE(1)) dut_s1 (
    .clk(clk), .rst(rst),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .kernel_load(kernel_load), .valid_in(valid_in), .valid_out(valid_out),
    .data_out(data_out_s1)
  );

  conv4 #(.STRIDE(2)) dut_s2 (
    .clk(clk), .rst(rst),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .kernel_load(kernel_load), .valid_in(valid_in), .valid_out(valid_out),
    .data_out(data_out_s2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: weights, window, load column, fill count, stride-2 phase, held outputs.
  logic signed [15:0] mw [4][4];
  logic signed [15:0] mx [4][4];
  logic [1:0]  mkc;
  int          mfill;
  int          mph2;
  logic [31:0] exp1;
  logic [31:0] exp2;
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  function automatic logic [31:0] model_dot();
    longint s = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s += longint'(mw[r][c]) * longint'(mx[r][c]);
    return s[31:0];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mw[r][c] = '0;
        mx[r][c] = '0;
      end
    mkc = 2'd0; mfill = 0; mph2 = 0; exp1 = '0; exp2 = '0;
    q1.delete(); q2.delete();
  endtask

  // Drive one beat, advance the reference, push expected outputs, wait past the edge.
  task automatic beat(input logic ld, input logic vi, input logic vo,
                      input logic [15:0] p0, input logic [15:0] p1,
                      input logic [15:0] p2, input logic [15:0] p3);
    logic [15:0] p [4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    data_in0 = {$urandom(), 16'($urandom()), p0};
    data_in1 = {$urandom(), 16'($urandom()), p1};
    data_in2 = {$urandom(), 16'($urandom()), p2};
    data_in3 = {$urandom(), 16'($urandom()), p3};
    kernel_load = ld; valid_in = vi; valid_out = vo;
    if (vi) begin
      if (ld) begin
        for (int r = 0; r < 4; r++) mw[r][mkc] = p[r];
        mkc = mkc + 2'd1; mfill = 0; mph2 = 0;
      end else begin
        mkc = 2'd0;
        for (int r = 0; r < 4; r++) begin
          mx[r][0] = mx[r][1]; mx[r][1] = mx[r][2]; mx[r][2] = mx[r][3]; mx[r][3] = p[r];
        end
        if (mfill < 4) mfill++;
        if (mfill == 4) begin
          if (vo) exp1 = model_dot();
          if (vo && mph2 == 0) exp2 = model_dot();
          mph2 = (mph2 == 1) ? 0 : 1;
        end
      end
    end
    q1.push_back(exp1);
    q2.push_back(exp2);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic kload(input logic [15:0] k [4][4]);
    logic [31:0] e1, e2;
    for (int c = 0; c < 4; c++) begin
      beat(1'b1, 1'b1, 1'b1, k[0][c], k[1][c], k[2][c], k[3][c]);
      e1 = q1.pop_front(); e2 = q2.pop_front();
      n_checks += 2;
      if (data_out_s1 !== e1) begin n_fail++; $display("FAIL kload_s1 col %0d: data_out=%h expected=%h", c, data_out_s1, e1); end
      if (data_out_s2 !== e2) begin n_fail++; $display("FAIL kload_s2 col %0d: data_out=%h expected=%h", c, data_out_s2, e2); end
    end
  endtask

  task automatic test_reset();
    logic [31:0] e1, e2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in0 = {$urandom(), $urandom()}; data_in1 = {$urandom(), $urandom()};
      data_in2 = {$urandom(), $urandom()}; data_in3 = {$urandom(), $urandom()};
      kernel_load = 1'($urandom()); valid_in = 1'b1; valid_out = 1'b1;
      @(posedge clk); #1;
    end
    n_checks += 2;
    if (data_out_s1 !== 32'd0) begin n_fail++; $display("FAIL reset_s1: data_out=%h expected=0", data_out_s1); end
    if (data_out_s2 !== 32'd0) begin n_fail++; $display("FAIL reset_s2: data_out=%h expected=0", data_out_s2); end
    valid_in = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      beat(1'b0, 1'b1, 1'b1, 16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
      e1 = q1.pop_front(); e2 = q2.pop_front();
      n_checks += 2;
      if (data_out_s1 !== e1) begin n_fail++; $display("FAIL noload_s1 beat %0d: data_out=%h expected=%h", i, data_out_s1, e1); end
      if (data_out_s2 !== e2) begin n_fail++; $display("FAIL noload_s2 beat %0d: data_out=%h expected=%h", i, data_out_s2, e2); end
    end
    n_checks++;
    if (data_out_s1 !== 32'd0) begin n_fail++; $display("FAIL noload_zero: data_out=%h expected=0", data_out_s1); end
  endtask

  task automatic test_all_ones();
    logic [15:0] k [4][4];
    logic [31:0] e1, e2;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) k[r][c] = 16'd1;
    kload(k);
    for (int i = 0; i < 6; i++) begin
      beat(1'b0, 1'b1, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4);
      e1 = q1.pop_front(); e2 = q2.pop_front();
      n_checks += 3;
      if (data_out_s1 !== e1) begin n_fail++; $display("FAIL ones_s1 beat %0d: data_out=%h expected=%h", i, data_out_s1, e1); end
      if (data_out_s2 !== e2) begin n_fail++; $display("FAIL ones_s2 beat %0d: data_out=%h expected=%h", i, data_out_s2, e2); end
      if (data_out_s1 !== ((i < 3) ? 32'd0 : 32'd40)) begin
        n_fail++; $display("FAIL ones_const beat %0d: data_out=%0d expected=%0d", i, data_out_s1, (i < 3) ? 0 : 40);
      end
    end
  endtask

  task automatic test_single_tap();
    logic [15:0] k [4][4];
    logic [31:0] e1, e2;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) k[r][c] = 16'd0;
    k[0][0] = 16'd2;
    kload(k);
    for (int i = 0; i < 5; i++) begin
      beat(1'b0, 1'b1, 1'b1, 16'(5 + i), 16'd0, 16'd0, 16'd0);
      e1 = q1.pop_front(); e2 = q2.pop_front();
      n_checks += 2;
      if (data_out_s1 !== e1) begin n_fail++; $display("FAIL tap_s1 beat %0d: data_out=%h expected=%h", i, data_out_s1, e1); end
      if (data_out_s2 !== e2) begin n_fail++; $display("FAIL tap_s2 beat %0d: data_out=%h expected=%h", i, data_out_s2, e2); end
      if (i == 3) begin
        n_checks++;
        if (data_out_s1 !== 32'd10) begin n_fail++; $display("FAIL tap_first: data_out=%0d expected=10", data_out_s1); end
      end
      if (i == 4) begin
        n_checks += 2;
        if (data_out_s1 !== 32'd12) begin n_fail++; $display("FAIL tap_second: data_out=%0d expected=12", data_out_s1); end
        if (data_out_s2 !== 32'd10) begin n_fail++; $display("FAIL tap_stride_hold: data_out=%0d expected=10", data_out_s2); end
      end
    end
  endtask

  task automatic test_signed_gated();
    logic [15:0] k [4][4];
    logic [31:0] e1, e2;
    logic [2:0]  ctl [9] = '{3'b011, 3'b101, 3'b011, 3'b001, 3'b011, 3'b010, 3'b000, 3'b011, 3'b011};
    logic [15:0] pix [9] = '{16'd1, 16'd7, 16'd1, 16'd7, 16'd1, 16'd1, 16'd7, 16'd1, 16'd1};
    logic [2:0]  cur;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) k[r][c] = 16'hFFFF;
    kload(k);
    for (int i = 0; i < 9; i++) begin
      cur = ctl[i];
      beat(cur[2], cur[1], cur[0], pix[i], pix[i], pix[i], pix[i]);
      e1 = q1.pop_front(); e2 = q2.pop_front();
      n_checks += 2;
      if (data_out_s1 !== e1) begin n_fail++; $display("FAIL gated_s1 beat %0d: data_out=%h expected=%h", i, data_out_s1, e1); end
      if (data_out_s2 !== e2) begin n_fail++; $display("FAIL gated_s2 beat %0d: data_out=%h expected=%h", i, data_out_s2, e2); end
      if (i == 5) begin
        n_checks++;
        if (data_out_s1 !== 32'd12) begin n_fail++; $display("FAIL gated_hold: data_out=%h expected=0000000c", data_out_s1); end
      end
      if (i == 7) begin
        n_checks += 2;
        if (data_out_s1 !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL signed_s1: data_out=%h expected=fffffff0", data_out_s1); end
        if (data_out_s2 !== 32'd10) begin n_fail++; $display("FAIL gated_phase_s2: data_out=%h expected=0000000a", data_out_s2); end
      end
      if (i == 8) begin
        n_checks++;
        if (data_out_s2 !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL signed_s2: data_out=%h expected=fffffff0", data_out_s2); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] k [4][4];
    logic [31:0] e1, e2;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) k[r][c] = 16'h7FFF;
    kload(k);
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, 1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      e1 = q1.pop_front(); e2 = q2.pop_front();
      n_checks += 2;
      if (data_out_s1 !== e1) begin n_fail++; $display("FAIL ovf_s1 beat %0d: data_out=%h expected=%h", i, data_out_s1, e1); end
      if (data_out_s2 !== e2) begin n_fail++; $display("FAIL ovf_s2 beat %0d: data_out=%h expected=%h", i, data_out_s2, e2); end
    end
    n_checks += 2;
    if (data_out_s1 !== 32'hFFF0_0010) begin n_fail++; $display("FAIL wrap_s1: data_out=%h expected=fff00010", data_out_s1); end
    if (data_out_s2 !== 32'hFFF0_0010) begin n_fail++; $display("FAIL wrap_s2: data_out=%h expected=fff00010", data_out_s2); end
  endtask

  task automatic test_stride_reload();
    logic [15:0] k [4][4];
    logic [31:0] e1, e2, s2_col4, s2_col6, s1_col7;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) k[r][c] = 16'(4 * r + c + 1);
    kload(k);
    for (int j = 1; j <= 7; j++) begin
      beat(1'b0, 1'b1, 1'b1, 16'(j), 16'(j + 10), 16'(j + 20), 16'(j + 30));
      e1 = q1.pop_front(); e2 = q2.pop_front();
      n_checks += 2;
      if (data_out_s1 !== e1) begin n_fail++; $display("FAIL stride_s1 col %0d: data_out=%h expected=%h", j, data_out_s1, e1); end
      if (data_out_s2 !== e2) begin n_fail++; $display("FAIL stride_s2 col %0d: data_out=%h expected=%h", j, data_out_s2, e2); end
      if (j == 4) s2_col4 = e1;
      if (j == 6) s2_col6 = e1;
      if (j == 5 || j == 7) begin
        n_checks++;
        if (data_out_s2 !== ((j == 5) ? s2_col4 : s2_col6)) begin
          n_fail++; $display("FAIL stride_skip col %0d: data_out=%h expected=%h", j, data_out_s2, (j == 5) ? s2_col4 : s2_col6);
        end
      end
      if (j == 7) s1_col7 = e1;
    end
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) k[r][c] = 16'd1;
    kload(k);
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, 1'b1, 1'b1, 16'(i + 1), 16'(i + 1), 16'(i + 1), 16'(i + 1));
      e1 = q1.pop_front(); e2 = q2.pop_front();
      n_checks += 3;
      if (data_out_s1 !== e1) begin n_fail++; $display("FAIL reload_s1 beat %0d: data_out=%h expected=%h", i, data_out_s1, e1); end
      if (data_out_s2 !== e2) begin n_fail++; $display("FAIL reload_s2 beat %0d: data_out=%h expected=%h", i, data_out_s2, e2); end
      if (data_out_s1 !== ((i < 3) ? s1_col7 : 32'd40)) begin
        n_fail++; $display("FAIL reload_fill beat %0d: data_out=%h expected=%h", i, data_out_s1, (i < 3) ? s1_col7 : 32'd40);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] e1, e2;
    beat(1'b0, 1'b1, 1'b1, 16'd1, 16'd1, 16'd1, 16'd1);
    beat(1'b0, 1'b1, 1'b1, 16'd1, 16'd1, 16'd1, 16'd1);
    q1.delete(); q2.delete();
    #2 rst = 1'b0;
    #1;
    n_checks += 2;
    if (data_out_s1 !== 32'd0) begin n_fail++; $display("FAIL async_rst_s1: data_out=%h expected=0", data_out_s1); end
    if (data_out_s2 !== 32'd0) begin n_fail++; $display("FAIL async_rst_s2: data_out=%h expected=0", data_out_s2); end
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, 1'b1, 1'b1, 16'd5, 16'd6, 16'd7, 16'd8);
      e1 = q1.pop_front(); e2 = q2.pop_front();
      n_checks += 2;
      if (data_out_s1 !== e1) begin n_fail++; $display("FAIL postrst_s1 beat %0d: data_out=%h expected=%h", i, data_out_s1, e1); end
      if (data_out_s2 !== e2) begin n_fail++; $display("FAIL postrst_s2 beat %0d: data_out=%h expected=%h", i, data_out_s2, e2); end
    end
    n_checks++;
    if (data_out_s1 !== 32'd0) begin n_fail++; $display("FAIL weights_cleared: data_out=%h expected=0", data_out_s1); end
  endtask

  task automatic test_random();
    logic [15:0] k [4][4];
    logic [31:0] e1, e2;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) k[r][c] = 16'($urandom());
    kload(k);
    for (int i = 0; i < 80; i++) begin
      beat(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
           16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
      e1 = q1.pop_front(); e2 = q2.pop_front();
      n_checks += 2;
      if (data_out_s1 !== e1) begin n_fail++; $display("FAIL rand_s1 beat %0d: data_out=%h expected=%h", i, data_out_s1, e1); end
      if (data_out_s2 !== e2) begin n_fail++; $display("FAIL rand_s2 beat %0d: data_out=%h expected=%h", i, data_out_s2, e2); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_all_ones();
    test_single_tap();
    test_signed_gated();
    test_overflow();
    test_stride_reload();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
